// File: rtl/stepper_ramp_drive.sv
// Stepper drive: programmable step period, full/half-step coil sequencing,
// saturating speed ramp requests and signed position tracking.
module stepper_ramp_drive #(
    parameter int CNT_W       = 24,
    parameter int PERIOD_INIT = 15000,
    parameter int PERIOD_MIN  = 9000,
    parameter int PERIOD_MAX  = 29000,
    parameter int PERIOD_STEP = 2000,
    parameter int POS_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    dir,
    input  logic                    half_step,
    input  logic                    inc,
    input  logic                    dec,
    output logic [3:0]              coils,
    output logic                    step_pulse,
    output logic signed [POS_W-1:0] position,
    output logic [CNT_W-1:0]        period,
    output logic                    at_max_speed,
    output logic                    at_min_speed
);

    localparam logic [CNT_W:0] P_MIN  = (CNT_W+1)'(PERIOD_MIN);
    localparam logic [CNT_W:0] P_MAX  = (CNT_W+1)'(PERIOD_MAX);
    localparam logic [CNT_W:0] P_STEP = (CNT_W+1)'(PERIOD_STEP);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx, idx_nx, idx_delta;
    logic             inc_q, dec_q, inc_pend, dec_pend;
    logic             inc_rise, dec_rise, tick, apply;
    logic [CNT_W:0]   p_wide, p_up;
    logic [CNT_W-1:0] period_nx;

    function automatic logic [3:0] seq(input logic [2:0] i);
        case (i)
            3'd0: seq = 4'b1000;
            3'd1: seq = 4'b1100;
            3'd2: seq = 4'b0100;
            3'd3: seq = 4'b0110;
            3'd4: seq = 4'b0010;
            3'd5: seq = 4'b0011;
            3'd6: seq = 4'b0001;
            default: seq = 4'b1001;
        endcase
    endfunction

    assign inc_rise = inc & ~inc_q;
    assign dec_rise = dec & ~dec_q;
    assign tick     = enable && (cnt == period - CNT_W'(1));
    // While stopped there is no interval to protect, so requests apply at once.
    assign apply    = tick || !enable;

    // Even index in full-step mode means half-step was just left: snap to the neighbouring odd index.
    assign idx_delta = (half_step || !idx[0]) ? 3'd1 : 3'd2;
    assign idx_nx    = dir ? idx + idx_delta : idx - idx_delta;

    always_comb begin
        p_wide    = {1'b0, period};
        p_up      = p_wide + P_STEP;
        period_nx = period;
        if (inc_pend && !dec_pend)
            period_nx = (p_wide <= P_MIN + P_STEP) ? P_MIN[CNT_W-1:0] : period - P_STEP[CNT_W-1:0];
        else if (dec_pend && !inc_pend)
            period_nx = (p_up >= P_MAX) ? P_MAX[CNT_W-1:0] : p_up[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            period     <= CNT_W'(PERIOD_INIT);
            idx        <= 3'd1;
            position   <= '0;
            coils      <= 4'b0000;
            step_pulse <= 1'b0;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            inc_pend   <= 1'b0;
            dec_pend   <= 1'b0;
        end else begin
            inc_q      <= inc;
            dec_q      <= dec;
            step_pulse <= tick;
            if (!enable)   cnt <= '0;
            else if (tick) cnt <= '0;
            else           cnt <= cnt + CNT_W'(1);
            // A fresh edge in the apply cycle survives as the next pending request.
            if (apply) begin
                period   <= period_nx;
                inc_pend <= inc_rise;
                dec_pend <= dec_rise;
            end else begin
                inc_pend <= inc_pend | inc_rise;
                dec_pend <= dec_pend | dec_rise;
            end
            if (tick) begin
                idx      <= idx_nx;
                position <= dir ? position + POS_W'(1) : position - POS_W'(1);
                coils    <= seq(idx_nx);
            end else begin
                coils    <= enable ? seq(idx) : 4'b0000;
            end
        end
    end

    assign at_max_speed = (period == CNT_W'(PERIOD_MIN));
    assign at_min_speed = (period == CNT_W'(PERIOD_MAX));

endmodule

// File: tb/tb_stepper_ramp_drive.sv
// Randomised and directed bench for stepper_ramp_drive against a cycle-level
// behavioural model built from the step/period rules.
module tb_stepper_ramp_drive;
    localparam int CNT_W = 24, P_INIT = 10, P_MIN = 4, P_MAX = 16, P_STEP = 2, POS_W = 8;

    logic clk = 1'b0, rst = 1'b1;
    logic enable = 1'b0, dir = 1'b1, half_step = 1'b0, inc = 1'b0, dec = 1'b0;
    logic [3:0] coils;
    logic step_pulse, at_max_speed, at_min_speed;
    logic signed [POS_W-1:0] position;
    logic [CNT_W-1:0] period;

    int checks = 0, failures = 0;

    logic [3:0] seq_tab [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                4'b0010, 4'b0011, 4'b0001, 4'b1001};
    int m_cnt, m_period, m_idx, m_pos;
    bit m_ip, m_dp, m_inc_prev, m_dec_prev, m_sp;
    logic [3:0] m_coils;

    stepper_ramp_drive #(.CNT_W(CNT_W), .PERIOD_INIT(P_INIT), .PERIOD_MIN(P_MIN),
                         .PERIOD_MAX(P_MAX), .PERIOD_STEP(P_STEP), .POS_W(POS_W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .dir(dir), .half_step(half_step),
        .inc(inc), .dec(dec), .coils(coils), .step_pulse(step_pulse),
        .position(position), .period(period),
        .at_max_speed(at_max_speed), .at_min_speed(at_min_speed));

    always #5 clk = ~clk;

    task automatic model_reset();
        m_cnt = 0; m_period = P_INIT; m_idx = 1; m_pos = 0;
        m_ip = 0; m_dp = 0; m_inc_prev = 0; m_dec_prev = 0; m_sp = 0; m_coils = 4'b0000;
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_step();
        int d;
        bit tick, ir, dr;
        d = dir ? 1 : -1;
        tick = enable && (m_cnt == m_period - 1);
        ir = inc && !m_inc_prev;
        dr = dec && !m_dec_prev;
        m_inc_prev = inc; m_dec_prev = dec;
        if (tick || !enable) begin
            if (m_ip && !m_dp)      m_period = (m_period - P_STEP < P_MIN) ? P_MIN : m_period - P_STEP;
            else if (m_dp && !m_ip) m_period = (m_period + P_STEP > P_MAX) ? P_MAX : m_period + P_STEP;
            m_ip = ir; m_dp = dr;
        end else begin
            m_ip = m_ip | ir; m_dp = m_dp | dr;
        end
        m_cnt = (!enable || tick) ? 0 : m_cnt + 1;
        if (tick) begin
            if (half_step || (m_idx % 2 == 0)) m_idx = (m_idx + d + 8) % 8;
            else                               m_idx = (m_idx + 2 * d + 8) % 8;
            m_pos = m_pos + d;
            if (m_pos > 127)  m_pos -= 256;
            if (m_pos < -128) m_pos += 256;
        end
        m_coils = enable ? seq_tab[m_idx] : 4'b0000;
        m_sp = tick;
    endtask

    // One clock: step model, let DUT clock, compare everything on the falling edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        checks += 4;
        if (coils !== m_coils) begin
            failures++; $display("FAIL coils t=%0t got %b want %b", $time, coils, m_coils);
        end
        if (step_pulse !== m_sp) begin
            failures++; $display("FAIL step_pulse t=%0t got %b want %b", $time, step_pulse, m_sp);
        end
        if (int'(position) != m_pos) begin
            failures++; $display("FAIL position t=%0t got %0d want %0d", $time, position, m_pos);
        end
        if (period !== CNT_W'(m_period) || at_max_speed !== (m_period == P_MIN)
            || at_min_speed !== (m_period == P_MAX)) begin
            failures++;
            $display("FAIL period t=%0t got %0d/%b/%b want %0d", $time, period, at_max_speed, at_min_speed, m_period);
        end
    endtask

    task automatic wait_step(input string name);
        int n = 0;
        do begin cycle(); n++; end while (!step_pulse && n < 60);
        if (!step_pulse) begin
            failures++; $display("FAIL %s timeout got no step_pulse want step within 60", name);
        end
    endtask

    task automatic do_reset();
        inc = 0; dec = 0; enable = 0; dir = 1; half_step = 0;
        rst = 1; model_reset();
        @(negedge clk); @(negedge clk);
        rst = 0;
    endtask

    task automatic pulse(input bit up);
        if (up) inc = 1; else dec = 1;
        cycle();
        inc = 0; dec = 0;
        cycle();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (coils !== 4'b0000 || step_pulse !== 1'b0 || position !== '0 || period !== CNT_W'(10)
            || at_max_speed !== 1'b0 || at_min_speed !== 1'b0) begin
            failures++;
            $display("FAIL reset got coils=%b sp=%b pos=%0d per=%0d want 0000/0/0/10", coils, step_pulse, position, period);
        end
    endtask

    task automatic test_full_step();
        logic [3:0] exp_c [4] = '{4'b0110, 4'b0011, 4'b1001, 4'b1100};
        int n;
        do_reset();
        enable = 1; dir = 1; half_step = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin cycle(); n++; end while (!step_pulse && n < 60);
            checks++;
            if (n != 10 || coils !== exp_c[k] || int'(position) != k + 1) begin
                failures++;
                $display("FAIL full_step%0d got gap=%0d coils=%b pos=%0d want 10/%b/%0d", k, n, coils, position, exp_c[k], k + 1);
            end
        end
    endtask

    task automatic test_ramp();
        int exp_inc [4] = '{8, 6, 4, 4};
        do_reset();
        enable = 1;
        for (int k = 0; k < 4; k++) begin
            pulse(1); wait_step("ramp_inc");
            checks++;
            if (period !== CNT_W'(exp_inc[k])) begin
                failures++; $display("FAIL ramp_inc%0d got %0d want %0d", k, period, exp_inc[k]);
            end
        end
        checks++;
        if (at_max_speed !== 1'b1) begin failures++; $display("FAIL at_max_speed got %b want 1", at_max_speed); end
        for (int k = 0; k < 8; k++) begin
            pulse(0); wait_step("ramp_dec");
            checks++;
            if (period !== CNT_W'((4 + 2 * (k + 1) > 16) ? 16 : 4 + 2 * (k + 1))) begin
                failures++; $display("FAIL ramp_dec%0d got %0d want %0d", k, period, (4 + 2 * (k + 1) > 16) ? 16 : 4 + 2 * (k + 1));
            end
        end
        checks++;
        if (at_min_speed !== 1'b1) begin failures++; $display("FAIL at_min_speed got %b want 1", at_min_speed); end
    endtask

    task automatic test_both_pending();
        do_reset();
        enable = 1;
        pulse(1); pulse(0);
        wait_step("both1");
        wait_step("both2");
        checks++;
        if (period !== CNT_W'(10)) begin failures++; $display("FAIL both_pending got %0d want 10", period); end
    endtask

    task automatic test_half_reverse();
        logic [3:0] exp_c [5] = '{4'b1000, 4'b1001, 4'b0001, 4'b0011, 4'b0110};
        do_reset();
        enable = 1; dir = 0; half_step = 1;
        for (int k = 0; k < 5; k++) begin
            if (k == 3) half_step = 0;
            wait_step("half_rev");
            checks++;
            if (coils !== exp_c[k] || int'(position) != -(k + 1)) begin
                failures++;
                $display("FAIL half_rev%0d got %b/%0d want %b/%0d", k, coils, position, exp_c[k], -(k + 1));
            end
        end
    endtask

    task automatic test_wrap_disable();
        do_reset();
        for (int k = 0; k < 3; k++) pulse(1);
        cycle();
        checks++;
        if (period !== CNT_W'(4)) begin failures++; $display("FAIL disabled_inc got %0d want 4", period); end
        enable = 1; dir = 1;
        for (int k = 0; k < 127; k++) wait_step("wrap");
        checks++;
        if (int'(position) != 127) begin failures++; $display("FAIL pos127 got %0d want 127", position); end
        wait_step("wrap");
        checks++;
        if (int'(position) != -128) begin failures++; $display("FAIL pos_wrap got %0d want -128", position); end
        cycle(); cycle();
        enable = 0;
        cycle();
        checks++;
        if (coils !== 4'b0000 || step_pulse !== 1'b0) begin
            failures++; $display("FAIL disable got %b/%b want 0000/0", coils, step_pulse);
        end
        for (int k = 0; k < 6; k++) cycle();
        pulse(0); cycle();
        checks++;
        if (period !== CNT_W'(6)) begin failures++; $display("FAIL disabled_dec got %0d want 6", period); end
    endtask

    task automatic test_async_reset();
        int n = 0;
        do_reset();
        enable = 1;
        pulse(0);
        wait_step("pre_rst");
        cycle(); cycle();
        @(posedge clk);
        #2 rst = 1;
        #1;
        checks++;
        if (coils !== 4'b0000 || period !== CNT_W'(10)) begin
            failures++; $display("FAIL async_rst got %b/%0d want 0000/10", coils, period);
        end
        model_reset();
        enable = 0;
        @(negedge clk);
        rst = 0;
        cycle();
        enable = 1;
        do begin cycle(); n++; end while (!step_pulse && n < 60);
        checks++;
        if (n != 10) begin failures++; $display("FAIL first_step_after_rst got %0d want 10", n); end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            enable    = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 29) == 0) dir = ~dir;
            if ($urandom_range(0, 29) == 0) half_step = ~half_step;
            inc = ($urandom_range(0, 9) == 0) ? ~inc : inc;
            dec = ($urandom_range(0, 9) == 0) ? ~dec : dec;
            cycle();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_step();
        test_ramp();
        test_both_pending();
        test_half_reverse();
        test_wrap_disable();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stepper_ramp_drive.md
Name: stepper_ramp_drive

Overview:
Parametrised stepper-motor drive with four coil outputs. It generates step timing from a programmable period counter and steps coils through a full- or half-step sequence in either direction. Speed-up and slow-down requests change the period in fixed increments and saturate at limits instead of wrapping. It also tracks signed position and reports limit status; it replaces the single fixed-pattern square-wave generator in the motor-control path.

Parameters:
CNT_W, 24, width of period counter and period register
PERIOD_INIT, 15000, step period in clk cycles after reset
PERIOD_MIN, 9000, fastest allowed period; must be >= 2
PERIOD_MAX, 29000, slowest allowed period; must be < 2**CNT_W
PERIOD_STEP, 2000, period change per inc/dec request
POS_W, 16, width of signed position counter

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous reset, active-high
enable  in  1  1 = run and energise coils, 0 = stop with coils off
dir  in  1  1 = forward (index +1), 0 = reverse (index -1)
half_step  in  1  1 = 8-state half-step, 0 = 4-state full-step
inc  in  1  speed-up request; synchronous level, rising edge detected internally
dec  in  1  slow-down request; synchronous level, rising edge detected internally
coils  out  4  coil drive {A,B,A',B'}
step_pulse  out  1  one-cycle pulse on each step taken
position  out  POS_W  signed step count
period  out  CNT_W  current step period
at_max_speed  out  1  period == PERIOD_MIN
at_min_speed  out  1  period == PERIOD_MAX

Behaviour:
- Async reset values: cnt=0, period=PERIOD_INIT, idx=1, position=0, coils=0000, step_pulse=0, pending requests cleared, edge-detect registers cleared. Flags are combinational from period.
- Sequence table, idx 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001. Full-step uses odd indices only.
- coils = table[idx] when enable=1, else 0000. coils are registered, so they update 1 cycle after enable changes.
- Period counter: when enable=1, cnt increments each cycle. At cnt == period-1 ("tick"), cnt returns to 0. When enable=0, cnt is held at 0. First tick occurs `period` cycles after enable rises.
- On tick:
  - half_step=1: idx moves ±1 mod 8.
  - half_step=0: idx moves ±2 mod 8 if odd. If even (mode was just switched), idx moves ±1 to the adjacent odd index in the dir direction.
  - position moves ±1 with two's-complement wrap.
  - step_pulse=1 in the cycle after the tick, i.e. the same cycle the new coils value appears.
- inc/dec capture: a rising edge sets the inc_pend or dec_pend flag. A request is never lost, even if enable=0. Repeated edges before a tick do not accumulate (one pending each).
- Period update, applied on a tick, or immediately if enable=0:
  - inc only: period = max(period-PERIOD_STEP, PERIOD_MIN).
  - dec only: period = min(period+PERIOD_STEP, PERIOD_MAX).
  - both pending: no change.
  - Both pend flags clear when applied.
  - Arithmetic is done at CNT_W+1 bits before the clamp, so there is no underflow or overflow.
  - The new period governs the next interval. The current interval always completes with the old period.
- A new edge arriving in the same cycle as an apply is kept pending for the next apply.
- dir and half_step are sampled at the tick only. Changing them mid-interval does not disturb cnt.
- rst mid-interval: immediate return to reset values; coils go 0000 asynchronously.

Test Plan:
Params PERIOD_INIT=10, MIN=4, MAX=16, STEP=2, POS_W=8 for all runs.
1. Reset, enable=1, dir=1, half_step=0 -> step_pulse every 10 cycles; coils 0110, 0011, 1001, 1100 repeating; position 1, 2, 3, 4.
2. Three inc edges separated by ticks -> period 8, 6, 4; a fourth edge keeps period 4 with at_max_speed=1. Then six dec edges -> period 16, at_min_speed=1, and further dec edges hold 16.
3. inc and dec edges in the same interval -> period stays 10, both pend flags cleared after the tick.
4. half_step=1, dir=0 from idx=1 -> coils 1000, 1001, 0001, 0011, ...; position -1, -2, ... Switch to half_step=0 at even idx 6 -> next coils 0011 (idx 5), then 0110 (idx 3).
5. position at 127 plus one forward step -> position -128. enable=0 mid-interval -> coils 0000 next cycle, no step_pulse, cnt=0; an inc edge while disabled changes period immediately.
6. Assert rst asynchronously between clock edges mid-run -> coils 0000 and period=10 before the next clk edge; after release, the first step comes 10 cycles after enable.
